// File: rtl/dcache_tag_update_arbiter.sv
// Single writer of the L1D tag/valid port. It arbitrates L2 fills, single-line
// invalidates and a flush-all sweep, and drives a registered one-hot-or-zero write.
module dcache_tag_update_arbiter #(
  parameter int NUM_SETS  = 64,
  parameter int NUM_WAYS  = 4,
  parameter int TAG_WIDTH = 20,
  localparam int SET_W    = $clog2(NUM_SETS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fill_en,
  input  logic [NUM_WAYS-1:0]  fill_way_oh,
  input  logic [SET_W-1:0]     fill_set,
  input  logic [TAG_WIDTH-1:0] fill_tag,
  input  logic                 fill_valid,
  input  logic                 inv_req,
  input  logic [NUM_WAYS-1:0]  inv_way_oh,
  input  logic [SET_W-1:0]     inv_set,
  output logic                 inv_ack,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic [NUM_WAYS-1:0]  l2i_dtag_update_en_oh,
  output logic [SET_W-1:0]     l2i_dtag_update_set,
  output logic [TAG_WIDTH-1:0] l2i_dtag_update_tag,
  output logic                 l2i_dtag_update_valid
);

  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int CNT_W = $clog2(NUM_SETS * NUM_WAYS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SETS * NUM_WAYS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_WAYS-1:0]  en_oh_q, en_oh_d;
  logic [SET_W-1:0]     set_q, set_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 valid_q, valid_d;

  logic same_line;
  logic sweep_grant;

  // A same-line collision is acked but never written: the fill data is newer.
  always_comb begin
    same_line   = (fill_set == inv_set) && (fill_way_oh == inv_way_oh);
    inv_ack     = reset && inv_req && (!fill_en || same_line);
    sweep_grant = (state_q == SWEEP) && !fill_en && !(inv_req && inv_ack);
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    en_oh_d = '0;
    set_d   = '0;
    tag_d   = '0;
    valid_d = 1'b0;
    if (fill_en) begin
      en_oh_d = fill_way_oh;
      set_d   = fill_set;
      tag_d   = fill_tag;
      valid_d = fill_valid;
    end else if (inv_req) begin
      en_oh_d = inv_way_oh;
      set_d   = inv_set;
    end else if (sweep_grant) begin
      en_oh_d = NUM_WAYS'(1) << cnt_q[WAY_W-1:0];
      set_d   = cnt_q[CNT_W-1:WAY_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        // A lost arbitration simply holds the counter; the last grant wraps it to 0.
        if (sweep_grant) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and active-low; all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_oh_q <= '0;
      set_q   <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_oh_q <= en_oh_d;
      set_q   <= set_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  assign flush_busy            = (state_q != IDLE);
  assign flush_done            = (state_q == DONE);
  assign l2i_dtag_update_en_oh = en_oh_q;
  assign l2i_dtag_update_set   = set_q;
  assign l2i_dtag_update_tag   = tag_q;
  assign l2i_dtag_update_valid = valid_q;

  a_fill_way_onehot : assert property (@(posedge clk) disable iff (!reset)
    fill_en |-> $onehot0(fill_way_oh));
  a_inv_way_onehot : assert property (@(posedge clk) disable iff (!reset)
    inv_req |-> $onehot0(inv_way_oh));
  a_out_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(l2i_dtag_update_en_oh));

endmodule
